alu_divider: RTL and testbench
==============================

ALU_DIVIDER -- requirements
Module: alu_divider

Interface
REQ-001 Parameter N, default 8: divisor, quotient and remainder width; dividend is 2N bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 A  input  2N  dividend magnitude (same magnitude format as the multiplier product P).
REQ-006 B  input  N  divisor magnitude.
REQ-007 sign_A, sign_B  input  1 each  operand signs (1 = negative).
REQ-008 Q  output  N  quotient magnitude, registered.
REQ-009 R  output  N  remainder magnitude, registered.
REQ-010 Q_sign, R_sign  output  1 each  result signs, registered.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse when results are valid.
REQ-013 div_by_zero, overflow  output  1 each  error flags, registered.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, CHECK, RUN, DONE.
REQ-015 In IDLE with start=1 at edge E0: capture A, B, sign_A and sign_B; clear Q, R, both signs and both flags; go to CHECK.
REQ-016 Operand inputs SHALL be ignored outside that capture edge; later input changes do not affect the result.
REQ-017 CHECK, at edge E1: if B=0, set div_by_zero=1 and go to DONE.
REQ-018 CHECK, at edge E1: if B!=0 and A[2N-1:N] >= B, set overflow=1 and go to DONE.
REQ-019 CHECK, at edge E1: otherwise load partial remainder = A[2N-1:N] and shift register = A[N-1:0], clear the iteration counter, and go to RUN.
REQ-020 div_by_zero SHALL take priority over overflow; the two flags are never high together.
REQ-021 RUN SHALL perform one restoring iteration per clock:
- shift the next dividend bit (MSB first) into the N+1-bit partial remainder;
- if the result is >= B, subtract B and shift 1 into the quotient; else shift 0.
REQ-022 After exactly N RUN iterations (edges E2..E(N+1)): load Q and R, then go to DONE.
REQ-023 Q_sign SHALL be sign_A XOR sign_B, and R_sign SHALL be sign_A (truncating division).
REQ-024 Either sign SHALL be forced to 0 when its magnitude is 0.
REQ-025 On an error, Q, R and both signs SHALL be 0.
REQ-026 done SHALL be high only in the DONE state, for exactly one cycle; DONE returns to IDLE on the next edge unconditionally.
REQ-027 Latency SHALL be as follows, measured from start edge E0:
- normal: done high in the cycle after edge E(N+1), i.e. N+2 cycles;
- error: done high after E1, i.e. 2 cycles.
REQ-028 busy SHALL be 1 in CHECK and RUN and 0 in IDLE and DONE.
REQ-029 start SHALL be ignored in CHECK, RUN and DONE; no queuing.
REQ-030 Q, R, signs and flags SHALL hold their last values in IDLE until the next accepted start.
REQ-031 A start in the IDLE cycle immediately following DONE SHALL be accepted; back-to-back throughput is one operation per N+3 cycles.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE, independent of clk.
REQ-033 reset_n=0 SHALL immediately clear Q, R, Q_sign, R_sign, busy, done, div_by_zero, overflow, the counter and the internal registers to 0, including mid-operation.
REQ-034 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-035 A=100, B=7, signs 0 -> Q=14, R=2, signs 0, flags 0; done 10 cycles after start (N=8); busy high for 9 cycles.
REQ-036 A=100, sign_A=1, B=7, sign_B=0 -> Q=14, Q_sign=1, R=2, R_sign=1; A=0, sign_A=1, B=5 -> Q=0, R=0, both signs 0.
REQ-037 B=0, any A -> div_by_zero=1, overflow=0, Q=R=0, done 2 cycles after start.
REQ-038 Overflow boundary (B=8):
- A=0x0800 -> overflow=1, done at 2 cycles;
- A=0x07FF -> Q=255, R=7, flags 0.
REQ-039 Start pulsed again during RUN with different operands -> ignored; original result is returned.
REQ-040 reset_n low at cycle 5 of RUN -> all outputs 0 and IDLE immediately; a new start after release gives the correct result.

Source files
------------

// File: rtl/alu_divider.sv
// Sign-magnitude restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// state | meaning
// IDLE  | waiting for start; results hold
// CHECK | divide-by-zero / quotient-overflow screening
// RUN   | one restoring iteration per clock, N iterations
// DONE  | results valid, done pulses for one cycle
module alu_divider #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [2*N-1:0] A,
  input  logic [N-1:0]   B,
  input  logic           sign_A,
  input  logic           sign_B,
  output logic [N-1:0]   Q,
  output logic [N-1:0]   R,
  output logic           Q_sign,
  output logic           R_sign,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [2*N-1:0] a_reg;
  logic [N-1:0]   b_reg;
  logic           sa_reg, sb_reg;
  logic [N-1:0]   rem, sreg;
  logic [CW-1:0]  cnt;

  logic [N:0]     trial;
  logic           ge;
  logic [N-1:0]   rem_nxt, sreg_nxt;
  logic           last, b_zero, a_ovf;

  // sreg starts as the low dividend half and fills with quotient bits as they shift out
  always_comb begin
    trial    = {rem, sreg[N-1]};
    ge       = trial >= {1'b0, b_reg};
    rem_nxt  = ge ? N'(trial - {1'b0, b_reg}) : trial[N-1:0];
    sreg_nxt = {sreg[N-2:0], ge};
    last     = cnt == CW'(N - 1);
    b_zero   = b_reg == '0;
    a_ovf    = a_reg[2*N-1:N] >= b_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   state_nxt = (b_zero || a_ovf) ? DONE : RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CHECK) || (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      sa_reg      <= 1'b0;
      sb_reg      <= 1'b0;
      rem         <= '0;
      sreg        <= '0;
      cnt         <= '0;
      Q           <= '0;
      R           <= '0;
      Q_sign      <= 1'b0;
      R_sign      <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg       <= A;
            b_reg       <= B;
            sa_reg      <= sign_A;
            sb_reg      <= sign_B;
            Q           <= '0;
            R           <= '0;
            Q_sign      <= 1'b0;
            R_sign      <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        CHECK: begin
          if (b_zero) begin
            div_by_zero <= 1'b1;
          end else if (a_ovf) begin
            overflow <= 1'b1;
          end else begin
            rem  <= a_reg[2*N-1:N];
            sreg <= a_reg[N-1:0];
            cnt  <= '0;
          end
        end
        RUN: begin
          rem  <= rem_nxt;
          sreg <= sreg_nxt;
          cnt  <= cnt + 1'b1;
          if (last) begin
            Q      <= sreg_nxt;
            R      <= rem_nxt;
            Q_sign <= (sa_reg ^ sb_reg) & (|sreg_nxt);
            R_sign <= sa_reg & (|rem_nxt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// Directed self-checking bench for alu_divider (N=8) with hand-computed expected results.
module tb_alu_divider;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [2*N-1:0] A = '0;
  logic [N-1:0]   B = '0;
  logic           sign_A = 1'b0;
  logic           sign_B = 1'b0;
  logic [N-1:0]   Q, R;
  logic           Q_sign, R_sign, busy, done, div_by_zero, overflow;

  int vectors = 0;
  int miscompares = 0;
  int lat, bcnt;

  alu_divider #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .A(A), .B(B),
    .sign_A(sign_A), .sign_B(sign_B), .Q(Q), .R(R), .Q_sign(Q_sign),
    .R_sign(R_sign), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Caller sits at a negedge; start is seen on the next rising edge, then inputs are scrambled.
  task automatic kick(input logic [2*N-1:0] a, input logic [N-1:0] b,
                      input logic sa, input logic sb);
    A = a; B = b; sign_A = sa; sign_B = sb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 16'($urandom); B = 8'($urandom);
    sign_A = 1'($urandom); sign_B = 1'($urandom);
  endtask

  // Counts sampled cycles after the start edge until done, then checks done is a single pulse.
  task automatic wait_done(input string tag, output int l, output int bc);
    l = 0; bc = 0;
    do begin
      @(negedge clk);
      l++;
      if (busy) bc++;
    end while (!done && l < 40);
    chk({tag, "_done_seen"}, 32'(done), 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {30'd0, done, busy}, 0);
  endtask

  task automatic chk_res(input string tag, input logic [N-1:0] q, input logic [N-1:0] r,
                         input logic qs, input logic rs, input logic dz, input logic ov);
    chk({tag, "_Q"}, 32'(Q), 32'(q));
    chk({tag, "_R"}, 32'(R), 32'(r));
    chk({tag, "_signs"}, {30'd0, Q_sign, R_sign}, {30'd0, qs, rs});
    chk({tag, "_flags"}, {30'd0, div_by_zero, overflow}, {30'd0, dz, ov});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {Q, R, Q_sign, R_sign, busy, done, div_by_zero, overflow}, 0);
    reset_n = 1'b1;

    // 100 / 7, accepted on the first edge after reset release
    kick(16'd100, 8'd7, 1'b0, 1'b0);
    wait_done("pos", lat, bcnt);
    chk("pos_latency", 32'(lat), 10);
    chk("pos_busy_cycles", 32'(bcnt), 9);
    chk_res("pos", 8'd14, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    // back-to-back: start in the IDLE cycle right after DONE
    kick(16'd100, 8'd7, 1'b1, 1'b0);
    wait_done("negA", lat, bcnt);
    chk("negA_latency", 32'(lat), 10);
    chk_res("negA", 8'd14, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0);

    kick(16'd50, 8'd7, 1'b0, 1'b1);
    wait_done("negB", lat, bcnt);
    chk_res("negB", 8'd7, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    kick(16'd0, 8'd5, 1'b1, 1'b0);
    wait_done("zeroA", lat, bcnt);
    chk_res("zeroA", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    kick(16'd1234, 8'd0, 1'b1, 1'b1);
    wait_done("dbz", lat, bcnt);
    chk("dbz_latency", 32'(lat), 2);
    chk("dbz_busy_cycles", 32'(bcnt), 1);
    chk_res("dbz", 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    kick(16'h0800, 8'd8, 1'b1, 1'b0);
    wait_done("ovf", lat, bcnt);
    chk("ovf_latency", 32'(lat), 2);
    chk_res("ovf", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    kick(16'h07FF, 8'd8, 1'b0, 1'b0);
    wait_done("ovf_edge", lat, bcnt);
    chk("ovf_edge_latency", 32'(lat), 10);
    chk_res("ovf_edge", 8'd255, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0);

    // results hold in IDLE
    repeat (3) @(negedge clk);
    chk_res("hold", 8'd255, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0);

    // start pulsed during RUN must be ignored
    kick(16'd200, 8'd9, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    A = 16'd10; B = 8'd3; sign_A = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore", lat, bcnt);
    chk_res("ignore", 8'd22, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("ignore_no_requeue", 32'(busy), 0);

    // async reset in the fifth RUN cycle
    kick(16'd200, 8'd9, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrun_reset", {Q, R, Q_sign, R_sign, busy, done, div_by_zero, overflow}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    kick(16'd1000, 8'd37, 1'b1, 1'b1);
    wait_done("post_reset", lat, bcnt);
    chk("post_reset_latency", 32'(lat), 10);
    chk_res("post_reset", 8'd27, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
